// File: rtl/mpu_irq_pkg.sv
// Shared types and helpers for the MPU interrupt scheduler.
// Holds the FSM state encoding, the vector width helper and the wait-counter width.
package mpu_irq_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    WAIT_ACK = 2'd2,
    GUARD    = 2'd3
  } state_e;

  localparam int TIMEOUT_CNT_W = 16;

  // A single source still needs a 1-bit vector.
  function automatic int vw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mpu_irq_sync.sv
// Level synchronizer that brings the interrupt latch output into int_clk.
// Every stage is cleared by the asynchronous reset.
module mpu_irq_sync
  import mpu_irq_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic int_clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], d};
  end

  always_ff @(posedge int_clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/mpu_irq_scheduler.sv
// Round-robin interrupt scheduler feeding the single cross-domain latch to the MPU.
// One grant is in flight at a time; the next waits for the synced latch to rise and fall.
module mpu_irq_scheduler
  import mpu_irq_pkg::*;
#(
  parameter int NUM_SRC     = 8,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 1023,
  parameter int GAP         = 2,
  localparam int VW         = vw(NUM_SRC)
) (
  input  logic               int_clk,
  input  logic               reset_n,
  input  logic [NUM_SRC-1:0] src_req,
  input  logic [NUM_SRC-1:0] src_mask,
  input  logic               latch_out,
  input  logic               ovf_clr,
  output logic               irq_trigger,
  output logic [VW-1:0]      irq_vector,
  output logic               irq_busy,
  output logic [NUM_SRC-1:0] pending,
  output logic [NUM_SRC-1:0] ovf,
  output logic [7:0]         timeout_cnt
);

  localparam logic [1:0] S_IDLE     = IDLE;
  localparam logic [1:0] S_ISSUE    = ISSUE;
  localparam logic [1:0] S_WAIT_ACK = WAIT_ACK;
  localparam logic [1:0] S_GUARD    = GUARD;

  localparam logic [TIMEOUT_CNT_W-1:0] TMO_LIM  = TIMEOUT_CNT_W'(TIMEOUT);
  // GAP = 0 collapses GUARD to a single cycle, same as GAP = 1.
  localparam logic [TIMEOUT_CNT_W-1:0] GAP_LAST = (GAP == 0) ? '0 : TIMEOUT_CNT_W'(GAP - 1);

  logic                     latch_s;
  logic [1:0]               state_q, state_d;
  logic [NUM_SRC-1:0]       pending_q, pending_d;
  logic [NUM_SRC-1:0]       ovf_q, ovf_d;
  logic [VW-1:0]            vec_q, vec_d;
  logic [VW-1:0]            rr_q, rr_d;
  logic [TIMEOUT_CNT_W-1:0] tmo_q, tmo_d;
  logic [TIMEOUT_CNT_W-1:0] gap_q, gap_d;
  logic [7:0]               tcnt_q, tcnt_d;
  logic                     trig_q, trig_d;
  logic [NUM_SRC-1:0]       elig;
  logic [NUM_SRC-1:0]       clr;
  logic [NUM_SRC-1:0]       restore;
  logic [VW-1:0]            winner;

  function automatic logic [VW-1:0] rr_pick(input logic [NUM_SRC-1:0] e,
                                            input logic [VW-1:0]      ptr);
    logic [VW-1:0] pick;
    logic          found;
    int            idx;
    pick  = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_SRC; k++) begin
      idx = (int'(ptr) + k) % NUM_SRC;
      if (!found && e[idx]) begin
        pick  = VW'(idx);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  function automatic logic [NUM_SRC-1:0] onehot(input logic [VW-1:0] i);
    return {{(NUM_SRC-1){1'b0}}, 1'b1} << i;
  endfunction

  mpu_irq_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .int_clk (int_clk),
    .reset_n (reset_n),
    .d       (latch_out),
    .q       (latch_s)
  );

  assign elig   = pending_q & src_mask;
  assign winner = rr_pick(elig, rr_q);

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    rr_d    = rr_q;
    tmo_d   = tmo_q;
    gap_d   = gap_q;
    tcnt_d  = tcnt_q;
    clr     = '0;
    restore = '0;
    case (state_q)
      S_IDLE: begin
        if (|elig) begin
          state_d = S_ISSUE;
          vec_d   = winner;
          rr_d    = (int'(winner) == NUM_SRC - 1) ? '0 : winner + VW'(1);
          tmo_d   = '0;
          clr     = onehot(winner);
        end
      end
      S_ISSUE: begin
        if (latch_s) begin
          state_d = S_WAIT_ACK;
        end else if (tmo_q == TMO_LIM) begin
          // Abandoned issue: hand the source back to arbitration.
          state_d = S_GUARD;
          gap_d   = '0;
          restore = onehot(vec_q);
          if (tcnt_q != 8'hFF) begin
            tcnt_d = tcnt_q + 8'd1;
          end
        end else begin
          tmo_d = tmo_q + TIMEOUT_CNT_W'(1);
        end
      end
      S_WAIT_ACK: begin
        if (!latch_s) begin
          state_d = S_GUARD;
          gap_d   = '0;
        end
      end
      default: begin
        if (gap_q == GAP_LAST) begin
          state_d = S_IDLE;
        end else begin
          gap_d = gap_q + TIMEOUT_CNT_W'(1);
        end
      end
    endcase

    // A request landing on its own grant cycle keeps the bit pending without overflow.
    pending_d = (pending_q & ~clr) | src_req | restore;
    ovf_d     = (ovf_clr ? '0 : ovf_q) | (src_req & pending_q & ~clr);
    trig_d    = (state_d == S_ISSUE);
  end

  always_ff @(posedge int_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      pending_q <= '0;
      ovf_q     <= '0;
      vec_q     <= '0;
      rr_q      <= '0;
      tmo_q     <= '0;
      gap_q     <= '0;
      tcnt_q    <= '0;
      trig_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      ovf_q     <= ovf_d;
      vec_q     <= vec_d;
      rr_q      <= rr_d;
      tmo_q     <= tmo_d;
      gap_q     <= gap_d;
      tcnt_q    <= tcnt_d;
      trig_q    <= trig_d;
    end
  end

  assign irq_trigger = trig_q;
  assign irq_vector  = vec_q;
  assign irq_busy    = (state_q != S_IDLE);
  assign pending     = pending_q;
  assign ovf         = ovf_q;
  assign timeout_cnt = tcnt_q;

endmodule
